pcr_arbiter: RTL and testbench

PCR_ARBITER -- requirements
Module: pcr_arbiter

---
 rtl/pcr_arbiter.sv | 131 +++++++++++++
 tb/tb_pcr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pcr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding PCR port.
// Optional WAIT timeout is enabled by defining PCR_ARB_TIMEOUT_EN.
module pcr_arbiter #(
    parameter logic CORE_ID        = 1'b0,
    parameter int   TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req0_valid_i,
    input  logic [11:0] req0_addr_i,
    input  logic [63:0] req0_data_i,
    input  logic [2:0]  req0_we_i,
    output logic        req0_ready_o,
    output logic        resp0_valid_o,
    output logic [63:0] resp0_data_o,
    output logic        resp0_err_o,
    input  logic        req1_valid_i,
    input  logic [11:0] req1_addr_i,
    input  logic [63:0] req1_data_i,
    input  logic [2:0]  req1_we_i,
    output logic        req1_ready_o,
    output logic        resp1_valid_o,
    output logic [63:0] resp1_data_o,
    output logic        resp1_err_o,
    input  logic        pcr_req_ready_i,
    output logic        pcr_req_valid_o,
    output logic [11:0] pcr_req_addr_o,
    output logic [63:0] pcr_req_data_o,
    output logic [2:0]  pcr_req_we_o,
    output logic        pcr_req_core_id_o,
    input  logic        pcr_resp_valid_i,
    input  logic [63:0] pcr_resp_data_i,
    input  logic        pcr_resp_core_id_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t       r_state, w_next;
    logic         r_last, r_gid;
    logic [11:0]  r_addr;
    logic [63:0]  r_data;
    logic [2:0]   r_we;
    logic [1:0]   r_resp_valid;
    logic [1:0][63:0] r_resp_data;
    logic         w_gnt, w_acc, w_match, w_done, w_tout;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        w_gnt   = (req0_valid_i && req1_valid_i) ? ~r_last : req1_valid_i;
        w_acc   = (r_state == S_IDLE) && (w_gnt ? req1_valid_i : req0_valid_i);
        w_match = pcr_resp_valid_i && (pcr_resp_core_id_i == CORE_ID);
        w_done  = (r_state == S_WAIT) && (w_match || w_tout);
    end

`ifdef PCR_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [1:0] r_resp_err;

    assign w_tout = (r_state == S_WAIT) && (r_cnt == 8'(TIMEOUT_CYCLES - 1)) && !w_match;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt      <= '0;
            r_resp_err <= '0;
        end else begin
            if (r_state == S_REQ && pcr_req_ready_i) r_cnt <= '0;
            else if (r_state == S_WAIT)              r_cnt <= r_cnt + 8'd1;
            if (w_done) r_resp_err[r_gid] <= !w_match;
        end
    end

    assign resp0_err_o = r_resp_err[0];
    assign resp1_err_o = r_resp_err[1];
`else
    assign w_tout      = 1'b0;
    assign resp0_err_o = 1'b0;
    assign resp1_err_o = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc)           w_next = S_REQ;
            S_REQ:   if (pcr_req_ready_i) w_next = S_WAIT;
            S_WAIT:  if (w_done)          w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_gid        <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= '0;
            if (w_acc) begin
                r_last <= w_gnt;
                r_gid  <= w_gnt;
                r_addr <= w_gnt ? req1_addr_i : req0_addr_i;
                r_data <= w_gnt ? req1_data_i : req0_data_i;
                r_we   <= w_gnt ? req1_we_i   : req0_we_i;
            end
            // A response arriving on the timeout cycle takes priority over the error.
            if (w_done) begin
                r_resp_valid[r_gid] <= 1'b1;
                r_resp_data[r_gid]  <= w_match ? pcr_resp_data_i : '1;
            end
        end
    end

    assign req0_ready_o      = (r_state == S_IDLE) && !w_gnt;
    assign req1_ready_o      = (r_state == S_IDLE) &&  w_gnt;
    assign pcr_req_valid_o   = (r_state == S_REQ);
    assign pcr_req_addr_o    = r_addr;
    assign pcr_req_data_o    = r_data;
    assign pcr_req_we_o      = r_we;
    assign pcr_req_core_id_o = CORE_ID;
    assign busy_o            = (r_state != S_IDLE);
    assign resp0_valid_o     = r_resp_valid[0];
    assign resp1_valid_o     = r_resp_valid[1];
    assign resp0_data_o      = r_resp_data[0];
    assign resp1_data_o      = r_resp_data[1];

endmodule

// File: tb/tb_pcr_arbiter.sv
// Directed bench for pcr_arbiter: reset, single transaction, round-robin,
// stall, response filtering, optional timeout and mid-transaction reset.
module tb_pcr_arbiter;
    logic        clk_i = 1'b0, rstn_i = 1'b0;
    logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [11:0] req0_addr_i, req1_addr_i, pcr_req_addr_o;
    logic [63:0] req0_data_i, req1_data_i, pcr_req_data_o, pcr_resp_data_i;
    logic [2:0]  req0_we_i, req1_we_i, pcr_req_we_o;
    logic        resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o;
    logic [63:0] resp0_data_o, resp1_data_o;
    logic        pcr_req_ready_i, pcr_req_valid_o, pcr_req_core_id_o;
    logic        pcr_resp_valid_i, pcr_resp_core_id_i, busy_o;
    int          vec = 0, miss = 0;

    pcr_arbiter #(.CORE_ID(1'b0), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_we_i(req0_we_i), .req0_ready_o(req0_ready_o),
        .resp0_valid_o(resp0_valid_o), .resp0_data_o(resp0_data_o), .resp0_err_o(resp0_err_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_we_i(req1_we_i), .req1_ready_o(req1_ready_o),
        .resp1_valid_o(resp1_valid_o), .resp1_data_o(resp1_data_o), .resp1_err_o(resp1_err_o),
        .pcr_req_ready_i(pcr_req_ready_i), .pcr_req_valid_o(pcr_req_valid_o),
        .pcr_req_addr_o(pcr_req_addr_o), .pcr_req_data_o(pcr_req_data_o),
        .pcr_req_we_o(pcr_req_we_o), .pcr_req_core_id_o(pcr_req_core_id_o),
        .pcr_resp_valid_i(pcr_resp_valid_i), .pcr_resp_data_i(pcr_resp_data_i),
        .pcr_resp_core_id_i(pcr_resp_core_id_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #1;
        vec++; if (busy_o !== 1'b0) begin miss++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        vec++; if (pcr_req_valid_o !== 1'b0) begin miss++; $display("FAIL rst_pcr_valid got %b exp 0", pcr_req_valid_o); end
        vec++; if ({resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o} !== 4'b0) begin miss++; $display("FAIL rst_resp got %b exp 0000", {resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o}); end
        vec++; if ({resp0_data_o, resp1_data_o} !== 128'h0) begin miss++; $display("FAIL rst_resp_data got %h %h exp 0", resp0_data_o, resp1_data_o); end
        vec++; if ({pcr_req_addr_o, pcr_req_data_o, pcr_req_we_o} !== 79'h0) begin miss++; $display("FAIL rst_payload got %h exp 0", {pcr_req_addr_o, pcr_req_data_o, pcr_req_we_o}); end
        vec++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin miss++; $display("FAIL rst_ready got %b exp 10", {req0_ready_o, req1_ready_o}); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_basic();
        pcr_req_ready_i = 1'b1;
        req0_valid_i = 1'b1; req0_addr_i = 12'hC00; req0_we_i = 3'd1; req0_data_i = 64'h1234;
        #1;
        vec++; if (req0_ready_o !== 1'b1) begin miss++; $display("FAIL basic_ready got %b exp 1", req0_ready_o); end
        step();
        req0_valid_i = 1'b0;
        vec++; if ({pcr_req_valid_o, busy_o, pcr_req_core_id_o} !== 3'b110) begin miss++; $display("FAIL basic_req got %b exp 110", {pcr_req_valid_o, busy_o, pcr_req_core_id_o}); end
        vec++; if ({pcr_req_addr_o, pcr_req_we_o, pcr_req_data_o} !== {12'hC00, 3'd1, 64'h1234}) begin miss++; $display("FAIL basic_payload got %h exp c00/1/1234", {pcr_req_addr_o, pcr_req_we_o, pcr_req_data_o}); end
        step();
        vec++; if ({pcr_req_valid_o, busy_o} !== 2'b01) begin miss++; $display("FAIL basic_wait got %b exp 01", {pcr_req_valid_o, busy_o}); end
        step();
        pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'hDEAD_BEEF;
        step();
        pcr_resp_valid_i = 1'b0;
        vec++; if ({resp0_valid_o, resp0_err_o, resp1_valid_o, busy_o} !== 4'b1000) begin miss++; $display("FAIL basic_pulse got %b exp 1000", {resp0_valid_o, resp0_err_o, resp1_valid_o, busy_o}); end
        vec++; if (resp0_data_o !== 64'hDEAD_BEEF) begin miss++; $display("FAIL basic_data got %h exp deadbeef", resp0_data_o); end
        step();
        vec++; if ({resp0_valid_o, resp0_data_o} !== {1'b0, 64'hDEAD_BEEF}) begin miss++; $display("FAIL basic_hold got %b %h exp 0 deadbeef", resp0_valid_o, resp0_data_o); end
    endtask

    task automatic test_round_robin();
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        step();
        req0_valid_i = 1'b1; req1_valid_i = 1'b1; pcr_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            automatic logic g = i[0];
            #1;
            vec++; if ({req0_ready_o, req1_ready_o} !== {~g, g}) begin miss++; $display("FAIL rr_grant%0d got %b exp %b", i, {req0_ready_o, req1_ready_o}, {~g, g}); end
            step();
            step();
            pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'h100 + 64'(i);
            step();
            pcr_resp_valid_i = 1'b0;
            vec++; if ({resp0_valid_o, resp1_valid_o} !== {~g, g}) begin miss++; $display("FAIL rr_resp%0d got %b exp %b", i, {resp0_valid_o, resp1_valid_o}, {~g, g}); end
            vec++; if ((g ? resp1_data_o : resp0_data_o) !== 64'h100 + 64'(i)) begin miss++; $display("FAIL rr_data%0d got %h exp %h", i, g ? resp1_data_o : resp0_data_o, 64'h100 + 64'(i)); end
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        step();
    endtask

    task automatic test_stall();
        pcr_req_ready_i = 1'b0;
        req0_valid_i = 1'b1; req0_addr_i = 12'h123; req0_data_i = 64'h0123_4567_89AB_CDEF; req0_we_i = 3'b101;
        req1_valid_i = 1'b1; req1_addr_i = 12'h456; req1_data_i = 64'h99; req1_we_i = 3'b010;
        #1;
        vec++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin miss++; $display("FAIL stall_grant got %b exp 10", {req0_ready_o, req1_ready_o}); end
        step();
        // Responses while in REQ must be ignored.
        pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'hBAD;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin pcr_req_ready_i = 1'b1; pcr_resp_valid_i = 1'b0; end
            vec++; if ({pcr_req_valid_o, req1_ready_o, resp0_valid_o} !== 3'b100) begin miss++; $display("FAIL stall_ctl%0d got %b exp 100", i, {pcr_req_valid_o, req1_ready_o, resp0_valid_o}); end
            vec++; if ({pcr_req_addr_o, pcr_req_data_o, pcr_req_we_o} !== {12'h123, 64'h0123_4567_89AB_CDEF, 3'b101}) begin miss++; $display("FAIL stall_payload%0d got %h", i, {pcr_req_addr_o, pcr_req_data_o, pcr_req_we_o}); end
            step();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        vec++; if ({pcr_req_valid_o, busy_o, req1_ready_o} !== 3'b010) begin miss++; $display("FAIL stall_wait got %b exp 010", {pcr_req_valid_o, busy_o, req1_ready_o}); end
        pcr_resp_valid_i = 1'b1; pcr_resp_data_i = 64'h55;
        step();
        pcr_resp_valid_i = 1'b0;
        vec++; if ({resp0_valid_o, resp0_data_o} !== {1'b1, 64'h55}) begin miss++; $display("FAIL stall_resp got %b %h exp 1 55", resp0_valid_o, resp0_data_o); end
    endtask

    task automatic test_mismatch();
        req1_valid_i = 1'b1; req1_addr_i = 12'h0AB;
        step();
        req1_valid_i = 1'b0;
        step();
        pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b1; pcr_resp_data_i = 64'hAAAA;
        step();
        vec++; if ({busy_o, resp0_valid_o, resp1_valid_o} !== 3'b100) begin miss++; $display("FAIL mm_ignore got %b exp 100", {busy_o, resp0_valid_o, resp1_valid_o}); end
        pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'hBBBB;
        step();
        pcr_resp_valid_i = 1'b0;
        vec++; if ({resp1_valid_o, resp1_err_o, resp0_valid_o, resp1_data_o} !== {3'b100, 64'hBBBB}) begin miss++; $display("FAIL mm_resp got %b %h exp 100 bbbb", {resp1_valid_o, resp1_err_o, resp0_valid_o}, resp1_data_o); end
        vec++; if (resp0_data_o !== 64'h55) begin miss++; $display("FAIL mm_other got %h exp 55", resp0_data_o); end
        step();
        pcr_resp_valid_i = 1'b1; pcr_resp_data_i = 64'hCCCC;
        step();
        pcr_resp_valid_i = 1'b0;
        vec++; if ({busy_o, resp0_valid_o, resp1_valid_o, resp1_data_o} !== {3'b000, 64'hBBBB}) begin miss++; $display("FAIL mm_idle got %b %h exp 000 bbbb", {busy_o, resp0_valid_o, resp1_valid_o}, resp1_data_o); end
    endtask

`ifdef PCR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req0_valid_i = 1'b1;
        step();
        req0_valid_i = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            vec++; if ({busy_o, resp0_valid_o} !== 2'b10) begin miss++; $display("FAIL to_wait%0d got %b exp 10", i, {busy_o, resp0_valid_o}); end
        end
        step();
        vec++; if ({resp0_valid_o, resp0_err_o, resp0_data_o} !== {2'b11, 64'hFFFF_FFFF_FFFF_FFFF}) begin miss++; $display("FAIL to_err got %b %h exp 11 ffff", {resp0_valid_o, resp0_err_o}, resp0_data_o); end
        req0_valid_i = 1'b1;
        step();
        req0_valid_i = 1'b0;
        step();
        step(); step(); step();
        pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'h77;
        step();
        pcr_resp_valid_i = 1'b0;
        vec++; if ({resp0_valid_o, resp0_err_o, resp0_data_o} !== {2'b10, 64'h77}) begin miss++; $display("FAIL to_race got %b %h exp 10 77", {resp0_valid_o, resp0_err_o}, resp0_data_o); end
    endtask
`endif

    task automatic test_reset_mid();
        req1_valid_i = 1'b1;
        step();
        req1_valid_i = 1'b0;
        step();
        vec++; if (busy_o !== 1'b1) begin miss++; $display("FAIL rm_busy got %b exp 1", busy_o); end
        rstn_i = 1'b0;
        #1;
        vec++; if ({busy_o, pcr_req_valid_o, resp1_data_o} !== {2'b00, 64'h0}) begin miss++; $display("FAIL rm_async got %b %h exp 00 0", {busy_o, pcr_req_valid_o}, resp1_data_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        pcr_resp_valid_i = 1'b1; pcr_resp_core_id_i = 1'b0; pcr_resp_data_i = 64'h88;
        step();
        pcr_resp_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec++; if ({busy_o, resp0_valid_o, resp1_valid_o} !== 3'b000) begin miss++; $display("FAIL rm_nopulse%0d got %b exp 000", i, {busy_o, resp0_valid_o, resp1_valid_o}); end
            step();
        end
    endtask

    initial begin
        {req0_valid_i, req1_valid_i, pcr_req_ready_i, pcr_resp_valid_i, pcr_resp_core_id_i} = '0;
        req0_addr_i = '0; req1_addr_i = '0; req0_data_i = '0; req1_data_i = '0;
        req0_we_i = '0; req1_we_i = '0; pcr_resp_data_i = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_mismatch();
`ifdef PCR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
